mul_acumulador: RTL

//  Downstream consumer of the 4x4 signed Booth multiplier. It watches the multiplier's result/Fin

---
 rtl/mul_acumulador.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mul_acumulador.sv
// mul_acumulador: captures signed products from the Booth multiplier on each Fin rise,
// accumulates N_PROD of them and delivers the batch sum through a valid/ready handshake.
module mul_acumulador #(
  parameter int N_PROD = 4,
  parameter int ACC_W  = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       result,
  input  logic             Fin,
  input  logic             clear,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             ovf,
  output logic             overrun,
  output logic [3:0]       count
);

  typedef enum logic {ACUM = 1'b0, ENTREGA = 1'b1} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_fin_d;
  logic             r_pend_vld;
  logic [7:0]       r_pend;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_overrun;
  logic [3:0]       r_count;

  logic             w_new;
  logic             w_add_en;
  logic             w_batch_done;
  logic             w_handshake;
  logic [7:0]       w_op8;
  logic [ACC_W-1:0] w_operand;
  logic [ACC_W-1:0] w_sum;
  logic             w_add_ovf;

  // A buffered product always has priority over a fresh one so products stay in order.
  assign w_new        = Fin & ~r_fin_d;
  assign w_add_en     = (r_state == ACUM) & (r_pend_vld | w_new);
  assign w_op8        = r_pend_vld ? r_pend : result;
  assign w_operand    = ACC_W'($signed(w_op8));
  assign w_sum        = r_acc + w_operand;
  assign w_add_ovf    = (r_acc[ACC_W-1] == w_operand[ACC_W-1]) &
                        (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
  assign w_batch_done = w_add_en & (r_count == 4'(N_PROD - 1));
  assign w_handshake  = (r_state == ENTREGA) & sum_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ACUM;
    else        r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = ACUM;
    end else begin
      case (r_state)
        ACUM:    if (w_batch_done) w_next_state = ENTREGA;
        ENTREGA: if (sum_ready)    w_next_state = ACUM;
        default: w_next_state = ACUM;
      endcase
    end
  end

  always_comb begin
    sum_valid = (r_state == ENTREGA);
    sum       = r_acc;
    ovf       = r_ovf;
    overrun   = r_overrun;
    count     = r_count;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fin_d    <= 1'b1;
      r_pend_vld <= 1'b0;
      r_pend     <= '0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_overrun  <= 1'b0;
      r_count    <= '0;
    end else begin
      r_fin_d <= Fin;
      if (clear) begin
        r_pend_vld <= 1'b0;
        r_pend     <= '0;
        r_acc      <= '0;
        r_ovf      <= 1'b0;
        r_overrun  <= 1'b0;
        r_count    <= '0;
      end else if (r_state == ACUM) begin
        if (w_add_en) begin
          r_acc   <= w_sum;
          r_count <= r_count + 4'd1;
          r_ovf   <= r_ovf | w_add_ovf;
        end
        r_pend_vld <= r_pend_vld & w_new;
        if (w_new) r_pend <= result;
      end else begin
        if (w_handshake) begin
          r_acc   <= '0;
          r_count <= '0;
          r_ovf   <= 1'b0;
        end
        if (w_new) begin
          if (!r_pend_vld) begin
            r_pend     <= result;
            r_pend_vld <= 1'b1;
          end else begin
            r_overrun  <= 1'b1;
          end
        end
      end
    end
  end

endmodule
